mmio_out_fifo: RTL

- Memory-mapped output port on the single-cycle MIPS computer's data-memory bus. Sits beside dmem and consumes the same memwrite/dataadr/writedata the CPU produces.
- Stores to DATA_ADDR are buffered in a small FIFO and drained to a downstream sink (display, UART, or the bench) over a valid/ready handshake.
- A status word is readable at STATUS_ADDR so software can poll for fullness and dropped writes.

---
 rtl/mmio_pkg.sv | 39 +++
 rtl/mmio_out_fifo_if.sv | 29 ++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/mmio_out_fifo.sv | 94 +++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared constants and status packing for the MMIO output FIFO
//
// Purpose: default register addresses, status-word bit positions and the
//          control-write clear bit, plus a helper that packs the status word.
// Ports:   none (package).

package mmio_pkg;

  localparam logic [31:0] DEFAULT_DATA_ADDR   = 32'h0000_0054;
  localparam logic [31:0] DEFAULT_STATUS_ADDR = 32'h0000_0058;

  localparam int ST_EMPTY    = 0;
  localparam int ST_FULL     = 1;
  localparam int ST_OVF      = 2;
  localparam int ST_CNT_LSB  = 4;
  localparam int ST_DROP_LSB = 8;

  localparam int CLR_OVF_BIT = 2;

  localparam int ST_WIDTH = 16;
  typedef logic [ST_WIDTH-1:0] status_t;

  // Bit 3 is reserved and always reads 0.
  function automatic status_t pack_status(input logic       empty,
                                          input logic       full,
                                          input logic       ovf,
                                          input logic [3:0] cnt,
                                          input logic [7:0] drop);
    status_t s;
    s                            = '0;
    s[ST_EMPTY]                  = empty;
    s[ST_FULL]                   = full;
    s[ST_OVF]                    = ovf;
    s[ST_CNT_LSB +: 4]           = cnt;
    s[ST_DROP_LSB +: 8]          = drop;
    return s;
  endfunction

endpackage

// File: rtl/mmio_out_fifo_if.sv
// rtl/mmio_out_fifo_if.sv - CPU data-bus and output-stream signals of the MMIO output port
//
// Purpose: bundles the CPU store/read bus and the valid/ready output stream.
// Signals: memwrite, dataadr, writedata (CPU -> port); hit, rdata (port -> CPU read mux);
//          out_valid, out_data (port -> sink); out_ready (sink -> port).
// Modports: slave = the output port itself, master = CPU/sink side.

interface mmio_out_fifo_if #(
  parameter int N = 32
);
  logic         memwrite;
  logic [N-1:0] dataadr;
  logic [N-1:0] writedata;
  logic         hit;
  logic [N-1:0] rdata;
  logic         out_valid;
  logic [N-1:0] out_data;
  logic         out_ready;

  modport slave (
    input  memwrite, dataadr, writedata, out_ready,
    output hit, rdata, out_valid, out_data
  );

  modport master (
    output memwrite, dataadr, writedata, out_ready,
    input  hit, rdata, out_valid, out_data
  );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - storage, pointers and occupancy count for the MMIO output FIFO
//
// Purpose: DEPTH-entry circular buffer; head entry is always visible on head.
// Ports:   clk, rst_n (async, active-low); push (accepted write, caller guarantees
//          room or a same-cycle pop), pop, wdata in; head, full, empty, count out.

module sync_fifo #(
  parameter int N     = 32,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [N-1:0] wdata,
  output logic [N-1:0] head,
  output logic         full,
  output logic         empty,
  output logic [3:0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [N-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]    count_q, count_d;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == 4'd0);
  assign full  = (count_q == 4'(DEPTH));

endmodule

// File: rtl/mmio_out_fifo.sv
// rtl/mmio_out_fifo.sv - memory-mapped output FIFO on the MIPS data-memory bus
//
// Purpose: stores to DATA_ADDR are queued and drained over out_valid/out_ready;
//          STATUS_ADDR reads {drop_count, count, overflow, full, empty} and a
//          write with bit 2 set clears overflow and drop_count.
// Ports:   clk; reset (async, active-low); bus (slave modport): memwrite, dataadr,
//          writedata in, hit, rdata out (combinational), out_valid, out_data out,
//          out_ready in.

module mmio_out_fifo
  import mmio_pkg::*;
#(
  parameter int           N           = 32,
  parameter int           DEPTH       = 8,
  parameter logic [N-1:0] DATA_ADDR   = N'(DEFAULT_DATA_ADDR),
  parameter logic [N-1:0] STATUS_ADDR = N'(DEFAULT_STATUS_ADDR)
) (
  input  logic             clk,
  input  logic             reset,
  mmio_out_fifo_if.slave   bus
);

  logic         sel_data, sel_status;
  logic         push_req, push_acc, pop, drop, clr;
  logic         full, empty;
  logic [3:0]   count;
  logic [N-1:0] head;

  logic         overflow_q, overflow_d;
  logic [7:0]   drop_count_q, drop_count_d;

  assign sel_data   = (bus.dataadr == DATA_ADDR);
  assign sel_status = (bus.dataadr == STATUS_ADDR);

  assign push_req = bus.memwrite & sel_data;
  assign clr      = bus.memwrite & sel_status & bus.writedata[CLR_OVF_BIT];
  assign pop      = ~empty & bus.out_ready;
  // A full FIFO still takes a store when the head leaves in the same cycle.
  assign push_acc = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  sync_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push_acc),
    .pop   (pop),
    .wdata (bus.writedata),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Clear takes priority over a same-cycle drop.
  always_comb begin
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (clr) begin
      overflow_d   = 1'b0;
      drop_count_d = 8'h00;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q   <= 1'b0;
      drop_count_q <= 8'h00;
    end else begin
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign bus.out_valid = ~empty;
  assign bus.out_data  = head;
  assign bus.hit       = sel_data | sel_status;

  // Data reads are gated by empty so uninitialised storage never leaks out.
  always_comb begin
    bus.rdata = '0;
    if (sel_data) begin
      if (!empty) bus.rdata = head;
    end else if (sel_status) begin
      bus.rdata = N'(pack_status(empty, full, overflow_q, count, drop_count_q));
    end
  end

endmodule
